sram_like_responder: RTL and testbench

SRAM_LIKE_RESPONDER -- requirements
Module: sram_like_responder

---
 rtl/sram_like_pkg.sv | 22 ++
 rtl/sram_like_responder_fifo.sv | 74 +++++++
 rtl/sram_like_responder.sv | 133 +++++++++++++
 tb/tb_sram_like_responder.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_pkg.sv
// Shared types and constants for the sram-like responder: access sizes,
// stall LFSR tap mask and the response queue entry.
package sram_like_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned LFSR_W = 16;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic              wr;
        logic [DATA_W-1:0] data;
    } resp_t;

    localparam int unsigned RESP_W = $bits(resp_t);

endpackage

// File: rtl/sram_like_responder_fifo.sv
// resp_fifo: synchronous circular response queue holding responses that
// could not be returned in the cycle their RAM data arrived.
module resp_fifo
    import sram_like_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              push,
    input  logic [RESP_W-1:0] push_data,
    input  logic              pop,
    output logic [RESP_W-1:0] head,
    output logic              empty,
    output logic              full
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [RESP_W-1:0] mem_q [DEPTH];
    logic [RESP_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push && (count_q != CNT_W'(DEPTH));
        do_pop   = pop && (count_q != '0);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/sram_like_responder.sv
// sram_like_responder: sram-like slave in front of a 1-cycle synchronous RAM.
// Optional random stall injection when SRAM_RESP_RANDOM_STALL_EN is defined.
module sram_like_responder
    import sram_like_pkg::*;
#(
    parameter int unsigned      FIFO_DEPTH = 2,
    parameter logic [15:0]      LFSR_SEED  = 16'hACE1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        ram_en,
    output logic [3:0]  ram_we,
    output logic [29:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic             ready_q, ready_d;
    logic             rvalid_q, rvalid_d;
    logic             rvalid_wr_q, rvalid_wr_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic             stall_a;
    logic             stall_d;
    logic             accept;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_empty;
    logic             fifo_full;
    resp_t            fifo_din;
    resp_t            fifo_head;
    logic             unused_c;

    // Sub-word addressing is irrelevant: the RAM is always accessed by word.
    assign unused_c = ^{size, addr[1:0]};

`ifdef SRAM_RESP_RANDOM_STALL_EN
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign stall_a = lfsr_q[0];
    assign stall_d = lfsr_q[1];
`else
    logic [15:0] seed_unused;

    assign seed_unused = LFSR_SEED;
    assign stall_a     = 1'b0;
    assign stall_d     = 1'b0;
`endif

    // Request side, response selection and bookkeeping.
    always_comb begin
        addr_ok   = ready_q && (outstanding_q < CNT_W'(FIFO_DEPTH)) && !stall_a;
        accept    = req && addr_ok;
        data_ok   = (!fifo_empty || rvalid_q) && !stall_d;
        fifo_pop  = data_ok && !fifo_empty;
        // Fresh RAM data is queued unless it bypasses straight to the initiator.
        fifo_push = rvalid_q && !(data_ok && fifo_empty) && !fifo_full;

        fifo_din.wr   = rvalid_wr_q;
        fifo_din.data = ram_rdata;

        rdata = '0;
        if (!fifo_empty) begin
            rdata = fifo_head.wr ? '0 : fifo_head.data;
        end else if (rvalid_q) begin
            rdata = rvalid_wr_q ? '0 : ram_rdata;
        end

        ram_en    = accept;
        ram_we    = (accept && wr) ? wstrb : 4'h0;
        ram_addr  = addr[31:2];
        ram_wdata = wdata;

        ready_d     = 1'b1;
        rvalid_d    = accept;
        rvalid_wr_d = accept ? wr : 1'b0;
        case ({accept, data_ok})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_q       <= 1'b0;
            rvalid_q      <= 1'b0;
            rvalid_wr_q   <= 1'b0;
            outstanding_q <= '0;
        end else begin
            ready_q       <= ready_d;
            rvalid_q      <= rvalid_d;
            rvalid_wr_q   <= rvalid_wr_d;
            outstanding_q <= outstanding_d;
        end
    end

    resp_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_resp_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (fifo_push),
        .push_data (fifo_din),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_sram_like_responder.sv
// Bench for sram_like_responder: directed scenarios plus random reads checked
// against an in-order expected-response queue and a shadow memory.
module tb_sram_like_responder;

    localparam int unsigned DEPTH     = 2;
    localparam int unsigned RAM_WORDS = 1024;
    localparam int unsigned N_RANDOM  = 1000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [29:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;

    logic [31:0] ram     [RAM_WORDS];
    logic [31:0] ref_mem [RAM_WORDS];
    logic [31:0] exp_q   [$];

    int checks = 0;
    int errors = 0;
    int accepted = 0;
    int a_forced_zero = 1;
    int d_mode = 0;          // 0: stall_d forced off, 1: forced on, 2: free-running
    logic        s_addr_ok;
    logic        s_data_ok;
    logic [31:0] s_rdata;
    logic [3:0]  s_ram_we;

    always #5 clk = ~clk;

    sram_like_responder #(
        .FIFO_DEPTH (DEPTH),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req       (req),
        .wr        (wr),
        .size      (size),
        .wstrb     (wstrb),
        .addr      (addr),
        .wdata     (wdata),
        .addr_ok   (addr_ok),
        .data_ok   (data_ok),
        .rdata     (rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // Synchronous read-first RAM with byte write enables.
    always @(posedge clk) begin
        if (ram_en) begin
            ram_rdata <= ram[ram_addr[9:0]];
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) ram[ram_addr[9:0]][8*b +: 8] = ram_wdata[8*b +: 8];
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: observed=still running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [3:0] s,
                         input logic [31:0] a, input logic [31:0] d);
        req   = r;
        wr    = w;
        wstrb = s;
        addr  = a;
        wdata = d;
        size  = 2'($urandom_range(0, 2));
    endtask

    // One clock cycle: sample at the falling edge, score, then step past the rising edge.
    task automatic tick();
        logic [31:0] e;
        logic        acc;
        int          idx;
        @(negedge clk);
        s_addr_ok = addr_ok;
        s_data_ok = data_ok;
        s_rdata   = rdata;
        s_ram_we  = ram_we;
        acc       = req && addr_ok;
        if (a_forced_zero != 0)
            chk("addr_ok_vs_outstanding", 32'(addr_ok), 32'(exp_q.size() < DEPTH));
        if (d_mode == 0)
            chk("data_ok_unstalled", 32'(data_ok), 32'(exp_q.size() != 0));
        else if (d_mode == 1)
            chk("data_ok_stalled", 32'(data_ok), 32'd0);
        if (data_ok) begin
            chk("spurious_data_ok", 32'(exp_q.size() == 0), 32'd0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rdata_in_order", rdata, e);
            end
        end
        chk("ram_en", 32'(ram_en), 32'(acc));
        if (acc) begin
            idx = int'(addr[11:2]);
            chk("ram_addr", {2'b00, ram_addr}, {2'b00, addr[31:2]});
            chk("ram_we", 32'(ram_we), wr ? 32'(wstrb) : 32'd0);
            if (wr) begin
                exp_q.push_back(32'd0);
                for (int b = 0; b < 4; b++)
                    if (wstrb[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                exp_q.push_back(ref_mem[idx]);
            end
            accepted++;
        end else begin
            chk("ram_we_idle", 32'(ram_we), 32'd0);
        end
        chk("outstanding_bound", 32'(exp_q.size() > DEPTH), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        while (exp_q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        chk("drain_complete", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic reset_outputs_check(input string tag);
        @(negedge clk);
        chk({tag, "_addr_ok"}, 32'(addr_ok), 32'd0);
        chk({tag, "_data_ok"}, 32'(data_ok), 32'd0);
        chk({tag, "_rdata"}, rdata, 32'd0);
        chk({tag, "_ram_en"}, 32'(ram_en), 32'd0);
        chk({tag, "_ram_we"}, 32'(ram_we), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < RAM_WORDS; i++) begin
            ram[i]     = 32'(i) * 32'h9E3779B1;
            ref_mem[i] = ram[i];
        end
        ram[0] = 32'h02800000;  ref_mem[0] = 32'h02800000;
        ram[4] = 32'h11223344;  ref_mem[4] = 32'h11223344;

        force dut.stall_a = 1'b0;
        force dut.stall_d = 1'b0;
        resetn = 1'b0;
        drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        reset_outputs_check("reset");

        // Release: addr_ok must stay low until the first rising edge.
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        resetn = 1'b1;
        #1;
        chk("release_addr_ok_before_edge", 32'(addr_ok), 32'd0);
        @(posedge clk);
        #1;

        // Single read with bypass latency.
        drive(1'b1, 1'b0, 4'h0, 32'h1c000000, 32'h0);
        tick();
        chk("first_read_addr_ok", 32'(s_addr_ok), 32'd1);
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        chk("first_read_data_ok", 32'(s_data_ok), 32'd1);
        chk("first_read_rdata", s_rdata, 32'h02800000);

        // Four back-to-back reads.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 4'h0, 32'(i * 4), 32'h0);
            tick();
            chk("b2b_addr_ok", 32'(s_addr_ok), 32'd1);
            if (i > 0) chk("b2b_data_ok", 32'(s_data_ok), 32'd1);
        end
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        chk("b2b_last_data_ok", 32'(s_data_ok), 32'd1);
        chk("b2b_last_rdata", s_rdata, 32'h9E3779B1 * 32'd3);

        // Partial write then read-back.
        drive(1'b1, 1'b1, 4'b0011, 32'h10, 32'hAABBCCDD);
        tick();
        chk("write_ram_we", 32'(s_ram_we), 32'h3);
        drive(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
        tick();
        chk("write_resp_data_ok", 32'(s_data_ok), 32'd1);
        chk("write_resp_rdata", s_rdata, 32'd0);
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        chk("readback_rdata", s_rdata, 32'h1122CCDD);

        // Stalled returns fill the queue and close addr_ok.
        force dut.stall_d = 1'b1;
        d_mode = 1;
        drive(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
        tick();
        drive(1'b1, 1'b0, 4'h0, 32'h24, 32'h0);
        tick();
        drive(1'b1, 1'b0, 4'h0, 32'h28, 32'h0);
        tick();
        chk("full_addr_ok", 32'(s_addr_ok), 32'd0);
        force dut.stall_d = 1'b0;
        d_mode = 0;
        tick();
        chk("full_pop_addr_ok", 32'(s_addr_ok), 32'd0);
        chk("full_pop_data_ok", 32'(s_data_ok), 32'd1);
        tick();
        chk("accept_and_return_addr_ok", 32'(s_addr_ok), 32'd1);
        chk("accept_and_return_data_ok", 32'(s_data_ok), 32'd1);
        force dut.stall_d = 1'b1;
        d_mode = 1;
        drive(1'b1, 1'b0, 4'h0, 32'h2C, 32'h0);
        tick();
        chk("refill_addr_ok", 32'(s_addr_ok), 32'd1);
        tick();
        chk("refull_addr_ok", 32'(s_addr_ok), 32'd0);
        force dut.stall_d = 1'b0;
        d_mode = 0;
        drain(10);

        // Reset with responses in flight discards them.
        force dut.stall_d = 1'b1;
        d_mode = 1;
        drive(1'b1, 1'b0, 4'h0, 32'h30, 32'h0);
        tick();
        drive(1'b1, 1'b0, 4'h0, 32'h34, 32'h0);
        tick();
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        resetn = 1'b0;
        exp_q.delete();
        force dut.stall_d = 1'b0;
        d_mode = 0;
        drive(1'b1, 1'b1, 4'hF, 32'h40, 32'h0);
        reset_outputs_check("midreset");
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        resetn = 1'b1;
        #1;
        chk("rerelease_addr_ok_before_edge", 32'(addr_ok), 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_reset_addr_ok", 32'(s_addr_ok), 32'd1);
            chk("post_reset_no_data_ok", 32'(s_data_ok), 32'd0);
        end

        // Random reads; stalls run free when the stall generator is built in.
`ifdef SRAM_RESP_RANDOM_STALL_EN
        release dut.stall_a;
        release dut.stall_d;
        a_forced_zero = 0;
        d_mode = 2;
`endif
        accepted = 0;
        for (int cyc = 0; cyc < 20000 && accepted < N_RANDOM; cyc++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'b0, 4'($urandom), $urandom, $urandom);
            tick();
        end
        chk("random_accept_count", 32'(accepted), 32'(N_RANDOM));
        drain(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
